// File: rtl/mmu_axi_rd_arb.sv
// AXI4 read-channel arbiter: CH_NUM requesters share one master AR/R port, one burst in flight.
// Define MMU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
module mmu_axi_rd_arb #(
    parameter int CH_NUM     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CH_NUM-1:0]            S_ARVALID,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] S_ARADDR,
    input  logic [CH_NUM*8-1:0]          S_ARLEN,
    output logic [CH_NUM-1:0]            S_ARREADY,
    output logic [CH_NUM-1:0]            S_RVALID,
    output logic [DATA_WIDTH-1:0]        S_RDATA,
    output logic [1:0]                   S_RRESP,
    output logic                         S_RLAST,
    output logic [ADDR_WIDTH-1:0]        M_AXI_ARADDR,
    output logic [7:0]                   M_AXI_ARLEN,
    output logic [2:0]                   M_AXI_ARSIZE,
    output logic [1:0]                   M_AXI_ARBURST,
    output logic                         M_AXI_ARVALID,
    input  logic                         M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]        M_AXI_RDATA,
    input  logic [1:0]                   M_AXI_RRESP,
    input  logic                         M_AXI_RLAST,
    input  logic                         M_AXI_RVALID,
    output logic                         M_AXI_RREADY,
    output logic                         BUSY,
    output logic                         LEN_ERR
);

    localparam int         PTR_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state, state_nxt;
    logic [CH_NUM-1:0]       grant;
    logic [CH_NUM-1:0]       win;
    logic [PTR_W-1:0]        win_idx;
    logic [ADDR_WIDTH-1:0]   addr_q, win_addr;
    logic [7:0]              len_q, win_len, beat_cnt;
    logic                    len_err;
    logic                    any_req;

    assign any_req  = |S_ARVALID;
    assign win      = CH_NUM'(1) << win_idx;
    assign win_addr = S_ARADDR[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len  = S_ARLEN[int'(win_idx)*8 +: 8];

`ifdef MMU_ARB_RR_EN
    logic [PTR_W-1:0] rr_ptr;
    logic             found;
    int               c;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        c       = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            c = (int'(rr_ptr) + 1 + i) % CH_NUM;
            if (!found && S_ARVALID[c]) begin
                found   = 1'b1;
                win_idx = PTR_W'(c);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rr_ptr <= PTR_W'(CH_NUM - 1);
        else if (state == IDLE && any_req)
            rr_ptr <= win_idx;
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (S_ARVALID[i]) win_idx = PTR_W'(i);
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ADDR;
            ADDR:    if (M_AXI_ARREADY) state_nxt = DATA;
            DATA:    if (M_AXI_RVALID && M_AXI_RLAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    grant  <= win;
                    addr_q <= win_addr;
                    len_q  <= win_len;
                end
                ADDR: if (M_AXI_ARREADY) beat_cnt <= '0;
                DATA: if (M_AXI_RVALID) begin
                    if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                    if (M_AXI_RLAST) grant <= '0;
                    // beat_cnt is the 0-based index of this beat; the last legal index is len_q.
                    if ((M_AXI_RLAST && beat_cnt != len_q) || (!M_AXI_RLAST && beat_cnt >= len_q))
                        len_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign BUSY          = (state != IDLE);
    assign LEN_ERR       = len_err;
    assign M_AXI_ARVALID = (state == ADDR);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = (state == ADDR) ? AR_SIZE : 3'b000;
    assign M_AXI_ARBURST = (state == ADDR) ? 2'b01 : 2'b00;
    assign M_AXI_RREADY  = (state == DATA);
    assign S_ARREADY     = (state == ADDR && M_AXI_ARREADY) ? grant : '0;
    assign S_RVALID      = (state == DATA && M_AXI_RVALID) ? grant : '0;
    assign S_RDATA       = (state == DATA) ? M_AXI_RDATA : '0;
    assign S_RRESP       = (state == DATA) ? M_AXI_RRESP : 2'b00;
    assign S_RLAST       = (state == DATA) ? M_AXI_RLAST : 1'b0;

endmodule

// File: tb/tb_mmu_axi_rd_arb.sv
// Directed bench for mmu_axi_rd_arb (CH_NUM=2): latency, arbitration order, stalls, length errors, reset.
module tb_mmu_axi_rd_arb;

    localparam int CH_NUM = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [CH_NUM-1:0]      S_ARVALID;
    logic [CH_NUM*AW-1:0]   S_ARADDR;
    logic [CH_NUM*8-1:0]    S_ARLEN;
    logic [CH_NUM-1:0]      S_ARREADY, S_RVALID;
    logic [DW-1:0]          S_RDATA;
    logic [1:0]             S_RRESP;
    logic                   S_RLAST;
    logic [AW-1:0]          M_AXI_ARADDR;
    logic [7:0]             M_AXI_ARLEN;
    logic [2:0]             M_AXI_ARSIZE;
    logic [1:0]             M_AXI_ARBURST;
    logic                   M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0]          M_AXI_RDATA;
    logic [1:0]             M_AXI_RRESP;
    logic                   M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
    logic                   BUSY, LEN_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mmu_axi_rd_arb #(.CH_NUM(CH_NUM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .S_ARVALID(S_ARVALID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARREADY(S_ARREADY), .S_RVALID(S_RVALID), .S_RDATA(S_RDATA),
        .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .BUSY(BUSY), .LEN_ERR(LEN_ERR)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic req(input int ch, input logic [31:0] addr, input logic [7:0] len, input bit v);
        S_ARADDR[ch*AW +: AW] = addr;
        S_ARLEN[ch*8 +: 8]    = len;
        S_ARVALID[ch]         = v;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Slave model: accepts the AR after ar_delay stall cycles, returns last_k+1 beats 0xA0+k.
    // Optionally raises another requester at beat raise_k to probe mid-burst isolation.
    task automatic serve(input int ch, input logic [31:0] addr, input logic [7:0] len,
                         input int last_k, input int ar_delay, input bit drop,
                         input int raise_ch, input int raise_k);
        int n;
        M_AXI_ARREADY = 1'b0;
        n = 0;
        while (!M_AXI_ARVALID && n < 50) begin
            @(negedge CLK); #1;
            n++;
        end
        chk("ar_wait", 64'(n), 64'd1);
        chk("araddr", M_AXI_ARADDR, addr);
        chk("arlen", M_AXI_ARLEN, len);
        for (int d = 0; d < ar_delay; d++) begin
            chk("stall_arvalid", M_AXI_ARVALID, 1);
            chk("stall_araddr", M_AXI_ARADDR, addr);
            chk("stall_s_arready", S_ARREADY, 0);
            @(negedge CLK); #1;
        end
        M_AXI_ARREADY = 1'b1;
        #1;
        chk("s_arready", S_ARREADY, 64'(1 << ch));
        chk("arsize", M_AXI_ARSIZE, 3'b010);
        chk("arburst", M_AXI_ARBURST, 2'b01);
        if (drop) S_ARVALID[ch] = 1'b0;
        @(negedge CLK);
        M_AXI_ARREADY = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            if (raise_ch >= 0 && k == raise_k) S_ARVALID[raise_ch] = 1'b1;
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = 32'hA0 + 32'(k);
            M_AXI_RLAST  = (k == last_k);
            #1;
            chk("s_rvalid", S_RVALID, 64'(1 << ch));
            chk("s_rdata", S_RDATA, 32'hA0 + 32'(k));
            chk("rready", M_AXI_RREADY, 1);
            chk("beat_s_arready", S_ARREADY, 0);
            @(negedge CLK);
        end
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        #1;
        chk("gap_busy", BUSY, 0);
        chk("gap_arvalid", M_AXI_ARVALID, 0);
    endtask

    initial begin
        int c;
        RST = 1'b1;
        S_ARVALID = '0; S_ARADDR = '0; S_ARLEN = '0;
        M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_araddr", M_AXI_ARADDR, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_s_arready", S_ARREADY, 0);
        chk("rst_s_rvalid", S_RVALID, 0);
        chk("rst_len_err", LEN_ERR, 0);
        @(negedge CLK);
        RST = 1'b0;

        // single 4-beat burst from ch0
        req(0, 32'h1000, 8'd3, 1'b1);
        serve(0, 32'h1000, 8'd3, 3, 0, 1'b1, -1, 0);
        chk("t1_len_err", LEN_ERR, 0);

        // both requesters held for four bursts
        do_reset();
        req(0, 32'h2000, 8'd1, 1'b1);
        req(1, 32'h3000, 8'd1, 1'b1);
        for (int b = 0; b < 4; b++) begin
`ifdef MMU_ARB_RR_EN
            c = b % 2;
`else
            c = 0;
`endif
            serve(c, (c == 1) ? 32'h3000 : 32'h2000, 8'd1, 1, 0, 1'b0, -1, 0);
        end
        S_ARVALID = '0;

        // ch1 arrives during a long ch0 burst
        req(1, 32'h6000, 8'd0, 1'b0);
        req(0, 32'h5000, 8'd7, 1'b1);
        serve(0, 32'h5000, 8'd7, 7, 0, 1'b1, 1, 2);
        serve(1, 32'h6000, 8'd0, 0, 0, 1'b1, -1, 0);

        // AR stalled for 5 cycles
        req(1, 32'h7000, 8'd2, 1'b1);
        serve(1, 32'h7000, 8'd2, 2, 5, 1'b1, -1, 0);
        chk("pre_err_len_err", LEN_ERR, 0);

        // early RLAST sets the sticky error; a clean burst does not clear it
        req(0, 32'h8000, 8'd3, 1'b1);
        serve(0, 32'h8000, 8'd3, 2, 0, 1'b1, -1, 0);
        chk("short_len_err", LEN_ERR, 1);
        req(1, 32'h9000, 8'd1, 1'b1);
        serve(1, 32'h9000, 8'd1, 1, 0, 1'b1, -1, 0);
        chk("sticky_len_err", LEN_ERR, 1);

        // reset during DATA
        req(0, 32'hA000, 8'd3, 1'b1);
        M_AXI_ARREADY = 1'b1;
        @(negedge CLK); #1;
        chk("mid_arvalid", M_AXI_ARVALID, 1);
        S_ARVALID[0] = 1'b0;
        @(negedge CLK);
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b1;
        M_AXI_RDATA   = 32'hA0;
        #1;
        chk("mid_s_rvalid", S_RVALID, 2'b01);
        RST = 1'b1;
        #1;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_rready", M_AXI_RREADY, 0);
        chk("mid_rst_s_rvalid", S_RVALID, 0);
        chk("mid_rst_len_err", LEN_ERR, 0);
        @(negedge CLK);
        RST = 1'b0;
        M_AXI_RVALID = 1'b0;
        req(1, 32'hA100, 8'd0, 1'b1);
        serve(1, 32'hA100, 8'd0, 0, 0, 1'b1, -1, 0);
        chk("post_rst_len_err", LEN_ERR, 0);

        // too many beats without RLAST
        req(0, 32'hB000, 8'd1, 1'b1);
        serve(0, 32'hB000, 8'd1, 3, 0, 1'b1, -1, 0);
        chk("long_len_err", LEN_ERR, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_axi_rd_arb.md
# mmu_axi_rd_arb

Parametrised AXI4 read-channel arbiter that lets `CH_NUM` cache/fetch requesters share one master AR/R port. It replaces wired-OR bus merging, which has no arbitration. The block grants one requester at a time and tracks exactly one outstanding burst. It issues the AR beat from registered values and routes R beats back only to the granted requester. It sits between the instruction/data caches and the external `M_AXI_*` read channels of the MMU.

## Interface
Parameters:
- `CH_NUM`, 2, number of requesters (1..8); index 0 is the highest fixed priority
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width (32 or 64)

Ports:
- `CLK`  in  1  clock; the only clock in the block
- `RST`  in  1  reset, asynchronous, active-high
- `S_ARVALID`  in  CH_NUM  per-requester read request
- `S_ARADDR`  in  CH_NUM*ADDR_WIDTH  request addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `S_ARLEN`  in  CH_NUM*8  burst lengths minus 1, packed the same way
- `S_ARREADY`  out  CH_NUM  one-hot request accept
- `S_RVALID`  out  CH_NUM  one-hot data-beat valid
- `S_RDATA`  out  DATA_WIDTH  broadcast read data
- `S_RRESP`  out  2  broadcast response
- `S_RLAST`  out  1  broadcast last beat
- `M_AXI_ARADDR`  out  ADDR_WIDTH, `M_AXI_ARLEN`  out  8, `M_AXI_ARSIZE`  out  3, `M_AXI_ARBURST`  out  2, `M_AXI_ARVALID`  out  1, `M_AXI_ARREADY`  in  1  AXI AR channel
- `M_AXI_RDATA`  in  DATA_WIDTH, `M_AXI_RRESP`  in  2, `M_AXI_RLAST`  in  1, `M_AXI_RVALID`  in  1, `M_AXI_RREADY`  out  1  AXI R channel
- `BUSY`  out  1  high whenever state is not IDLE
- `LEN_ERR`  out  1  sticky burst-length mismatch flag

## Operation
- The FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - If any `S_ARVALID` is high, select a winner, register its address, length and a one-hot grant, then go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - `M_AXI_ARVALID`=1; `ARADDR`/`ARLEN` come from the registers.
  - `M_AXI_ARSIZE` = log2(DATA_WIDTH/8), i.e. 3'b010 at 32 bits. `M_AXI_ARBURST`=2'b01 (INCR).
  - `S_ARREADY[grant]` = `M_AXI_ARREADY` in this state (combinational). On `M_AXI_ARREADY`, go to DATA and clear the beat counter.
- DATA:
  - `M_AXI_RREADY`=1.
  - `S_RVALID[grant]` = `M_AXI_RVALID`. `S_RDATA`/`S_RRESP`/`S_RLAST` pass through combinationally.
  - The 8-bit beat counter increments on each `M_AXI_RVALID`.
  - On `M_AXI_RVALID & M_AXI_RLAST`, go to IDLE and clear the grant.
- LEN_ERR: set when the RLAST beat's counter value ≠ the registered length, or when the counter would exceed the registered length without RLAST. The counter saturates at 255. LEN_ERR is cleared only by `RST`. The burst still completes on RLAST.
- Ungranted requesters see `S_ARREADY`=0 and `S_RVALID`=0 at all times.
- Requesters hold `S_ARVALID`/`S_ARADDR`/`S_ARLEN` until `S_ARREADY`. If a requester withdraws after being latched, the burst is still issued and returned to it.

## Timing
- Reset values: all outputs 0, state IDLE, grant 0, beat counter 0, `LEN_ERR` 0, round-robin pointer `CH_NUM-1`.
- Request arbitrated in IDLE at cycle 0 → `M_AXI_ARVALID` high at cycle 1. With `ARREADY` already high, `S_ARREADY` pulses in cycle 1 and DATA starts in cycle 2.
- Arbitration happens only in IDLE. Requests arriving in ADDR or DATA wait; the earliest next grant is the cycle after the RLAST beat (one IDLE cycle between bursts).
- `M_AXI_ARVALID` stays asserted with stable payload until `ARREADY` (AXI rule).
- Simultaneous requests: resolved by the arbitration policy in Configuration.
- `RVALID` while in IDLE or ADDR: `RREADY` is 0, so the beat is not consumed.
- `RST` mid-burst: the FSM returns to IDLE immediately and the outstanding AXI transaction is abandoned. The interconnect is reset by the same `RST`.

## Configuration
- `MMU_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at (last grant + 1) mod `CH_NUM`.
  - The pointer updates on each grant.
  - Reset pointer `CH_NUM-1` gives channel 0 the first win.
- Not defined: fixed priority. The lowest index wins and the pointer logic is removed.

## Test plan
- `CH_NUM`=2, ch0 reads 0x1000 `ARLEN`=3, slave returns 4 beats 0xA0..0xA3: `ARADDR`=0x1000 and `ARLEN`=3 at cycle 1; `S_RVALID`=2'b01 on 4 beats; `LEN_ERR`=0.
- ch0 and ch1 request simultaneously and hold their requests, four bursts: fixed priority serves ch0 every time. With `MMU_ARB_RR_EN` the order is ch0, ch1, ch0, ch1.
- ch1 requests while a ch0 `ARLEN`=7 burst is in DATA: ch1 `ARVALID` appears only after ch0's RLAST, with exactly one IDLE cycle between them; ch1 sees no `S_RVALID` during the ch0 burst.
- `ARLEN`=3 with the slave asserting RLAST on beat 2: the burst ends, `LEN_ERR`=1 and stays 1 across later good bursts until `RST`.
- `ARREADY` held low for 5 cycles: `ARVALID`/`ARADDR` stay stable, and `S_ARREADY` pulses once, on the handshake cycle.
- `RST` asserted mid-DATA: `BUSY`, `M_AXI_RREADY` and `S_RVALID` go 0 asynchronously, and a new request is granted after release.
